// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// lock timeout and the word-index window of the 32-word data memory.
package memory_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   // Word index is address[WORD_IDX_HI:WORD_IDX_LO]; anything above is out of range.
   localparam int WORD_IDX_HI = 6;
   localparam int WORD_IDX_LO = 2;
   localparam int MEM_WORDS   = 1 << (WORD_IDX_HI - WORD_IDX_LO + 1);

   // Owner releases the lock after this many consecutive idle cycles.
   localparam int                 LOCK_TIMEOUT = 16;
   localparam int                 TMO_W        = 4;
   localparam logic [TMO_W-1:0]   TMO_LAST     = TMO_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arb_state_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:WORD_IDX_HI+1] == '0;
   endfunction

endpackage

// File: rtl/memory_arbiter_rr.sv
// Two-way pick between port A and port B. Ties go to the port that was not
// granted last (or always to A in fixed-priority mode).
module rr_arbiter2
   import memory_arbiter_pkg::*;
#(
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);

   port_e last_q;
   port_e last_d;

   // Pick a winner and remember who won for the next tie.
   always_comb begin
      gnt_a  = 1'b0;
      gnt_b  = 1'b0;
      last_d = last_q;
      if (req_a && req_b) begin
         if (FIXED_PRIORITY || (last_q == PORT_B)) begin
            gnt_a = 1'b1;
         end else begin
            gnt_b = 1'b1;
         end
      end else begin
         gnt_a = req_a;
         gnt_b = req_b;
      end
      if (gnt_a) begin
         last_d = PORT_A;
      end else if (gnt_b) begin
         last_d = PORT_B;
      end
   end

   // Last-grant register; reset to B so A wins the first tie.
   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         last_q <= PORT_B;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates two requesters (A = CPU, B = loader/debug) onto a single
// 32-word memory with optional locked (atomic) ownership.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no owner; grants chosen by rr_arbiter2
//  OWN_A | A holds the lock; only A may be granted, B waits
//  OWN_B | B holds the lock; only B may be granted, A waits
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic              Clock,
   input  logic              ResetN,
   input  logic              ReqA,
   input  logic              ReqB,
   input  logic              WeA,
   input  logic              WeB,
   input  logic              LockA,
   input  logic              LockB,
   input  logic [ADDR_W-1:0] AddrA,
   input  logic [ADDR_W-1:0] AddrB,
   input  logic [DATA_W-1:0] WDataA,
   input  logic [DATA_W-1:0] WDataB,
   output logic              GntA,
   output logic              GntB,
   output logic              RValidA,
   output logic              RValidB,
   output logic [DATA_W-1:0] RDataA,
   output logic [DATA_W-1:0] RDataB,
   output logic              ErrA,
   output logic              ErrB,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [DATA_W-1:0] MemDataIn,
   output logic              MemEnableWrite,
   input  logic [DATA_W-1:0] MemDataOut
);

   arb_state_e        state_q;
   arb_state_e        state_d;
   logic [TMO_W-1:0]  tmo_q;
   logic [TMO_W-1:0]  tmo_d;

   logic              elig_a;
   logic              elig_b;
   logic              gnt_a;
   logic              gnt_b;
   logic              in_range_a;
   logic              in_range_b;

   logic              rvalid_a_q, rvalid_a_d;
   logic              rvalid_b_q, rvalid_b_d;
   logic [DATA_W-1:0] rdata_a_q,  rdata_a_d;
   logic [DATA_W-1:0] rdata_b_q,  rdata_b_d;
   logic              err_a_q,    err_a_d;
   logic              err_b_q,    err_b_d;

   // A port may compete only when the other port does not own the memory;
   // nothing is eligible while reset is asserted.
   always_comb begin
      elig_a = ResetN && ReqA && (state_q != OWN_B);
      elig_b = ResetN && ReqB && (state_q != OWN_A);
   end

   rr_arbiter2 #(
      .FIXED_PRIORITY (FIXED_PRIORITY)
   ) u_rr (
      .clk_sys (Clock),
      .rst_b   (ResetN),
      .req_a   (elig_a),
      .req_b   (elig_b),
      .gnt_a   (gnt_a),
      .gnt_b   (gnt_b)
   );

   assign GntA = gnt_a;
   assign GntB = gnt_b;

   // Route the granted port onto the memory bus; out-of-range writes are dropped.
   always_comb begin
      in_range_a     = addr_in_range(AddrA);
      in_range_b     = addr_in_range(AddrB);
      MemAddress     = '0;
      MemDataIn      = '0;
      MemEnableWrite = 1'b0;
      if (gnt_a) begin
         MemAddress     = AddrA;
         MemDataIn      = WDataA;
         MemEnableWrite = WeA && in_range_a;
      end else if (gnt_b) begin
         MemAddress     = AddrB;
         MemDataIn      = WDataB;
         MemEnableWrite = WeB && in_range_b;
      end
   end

   // Ownership FSM and lock timeout (counts consecutive idle cycles of the owner).
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (gnt_a && LockA) begin
               state_d = OWN_A;
            end else if (gnt_b && LockB) begin
               state_d = OWN_B;
            end
         end
         OWN_A: begin
            if (gnt_a) begin
               tmo_d = '0;
               if (!LockA) begin
                  state_d = IDLE;
               end
            end else if (tmo_q == TMO_LAST) begin
               tmo_d   = '0;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         OWN_B: begin
            if (gnt_b) begin
               tmo_d = '0;
               if (!LockB) begin
                  state_d = IDLE;
               end
            end else if (tmo_q == TMO_LAST) begin
               tmo_d   = '0;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tmo_d   = '0;
         end
      endcase
   end

   // Response for a grant in this cycle; the memory read is combinational so
   // MemDataOut already reflects the granted address (and any prior write).
   always_comb begin
      rvalid_a_d = gnt_a;
      rvalid_b_d = gnt_b;
      rdata_a_d  = (gnt_a && !WeA && in_range_a) ? MemDataOut : '0;
      rdata_b_d  = (gnt_b && !WeB && in_range_b) ? MemDataOut : '0;
      err_a_d    = gnt_a && !in_range_a;
      err_b_d    = gnt_b && !in_range_b;
   end

   // State, timeout and response registers.
   always_ff @(posedge Clock) begin
      if (!ResetN) begin
         state_q    <= IDLE;
         tmo_q      <= '0;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
         err_a_q    <= 1'b0;
         err_b_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         rvalid_a_q <= rvalid_a_d;
         rvalid_b_q <= rvalid_b_d;
         rdata_a_q  <= rdata_a_d;
         rdata_b_q  <= rdata_b_d;
         err_a_q    <= err_a_d;
         err_b_q    <= err_b_d;
      end
   end

   assign RValidA = rvalid_a_q;
   assign RValidB = rvalid_b_q;
   assign RDataA  = rdata_a_q;
   assign RDataB  = rdata_b_q;
   assign ErrA    = err_a_q;
   assign ErrB    = err_b_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: per-cycle vector table plus lock-timeout sequences.
module tb_memory_arbiter;

   logic        Clock;
   logic        ResetN;
   logic        ReqA, ReqB, WeA, WeB, LockA, LockB;
   logic [31:0] AddrA, AddrB, WDataA, WDataB;
   logic        GntA, GntB, RValidA, RValidB, ErrA, ErrB;
   logic [31:0] RDataA, RDataB;
   logic [31:0] MemAddress, MemDataIn, MemDataOut;
   logic        MemEnableWrite;

   int checks   = 0;
   int failures = 0;

   memory_arbiter dut (
      .Clock          (Clock),
      .ResetN         (ResetN),
      .ReqA           (ReqA),
      .ReqB           (ReqB),
      .WeA            (WeA),
      .WeB            (WeB),
      .LockA          (LockA),
      .LockB          (LockB),
      .AddrA          (AddrA),
      .AddrB          (AddrB),
      .WDataA         (WDataA),
      .WDataB         (WDataB),
      .GntA           (GntA),
      .GntB           (GntB),
      .RValidA        (RValidA),
      .RValidB        (RValidB),
      .RDataA         (RDataA),
      .RDataB         (RDataB),
      .ErrA           (ErrA),
      .ErrB           (ErrB),
      .MemAddress     (MemAddress),
      .MemDataIn      (MemDataIn),
      .MemEnableWrite (MemEnableWrite),
      .MemDataOut     (MemDataOut)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // 32-word data memory: word i preloaded with value i.
   logic [31:0] mem [32];
   logic        mem_load;
   always @(posedge Clock) begin
      if (mem_load) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
      end else if (MemEnableWrite) begin
         mem[MemAddress[6:2]] <= MemDataIn;
      end
   end
   assign MemDataOut = mem[MemAddress[6:2]];

   typedef struct {
      logic        rst_n;
      logic        req_a, we_a, lk_a;
      logic [31:0] addr_a, wd_a;
      logic        req_b, we_b, lk_b;
      logic [31:0] addr_b, wd_b;
      logic        g_a, g_b, mwe;
      logic [31:0] maddr;
      logic        rv_a;
      logic [31:0] rd_a;
      logic        er_a;
      logic        rv_b;
      logic [31:0] rd_b;
      logic        er_b;
      logic        chk_rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [31:0] rst,
                               ra, wa, la, aa, da,
                               rb, wb, lb, ab, db,
                               ga, gb, mw, ma,
                               rva, rda, era,
                               rvb, rdb, erb, ck);
      vec_t v;
      v.rst_n  = rst[0];
      v.req_a  = ra[0];  v.we_a = wa[0];  v.lk_a = la[0];  v.addr_a = aa;  v.wd_a = da;
      v.req_b  = rb[0];  v.we_b = wb[0];  v.lk_b = lb[0];  v.addr_b = ab;  v.wd_b = db;
      v.g_a    = ga[0];  v.g_b  = gb[0];  v.mwe  = mw[0];  v.maddr  = ma;
      v.rv_a   = rva[0]; v.rd_a = rda;    v.er_a = era[0];
      v.rv_b   = rvb[0]; v.rd_b = rdb;    v.er_b = erb[0];
      v.chk_rd = ck[0];
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge Clock);
      #1;
   endtask

   task automatic apply(input vec_t v);
      ResetN = v.rst_n;
      ReqA = v.req_a; WeA = v.we_a; LockA = v.lk_a; AddrA = v.addr_a; WDataA = v.wd_a;
      ReqB = v.req_b; WeB = v.we_b; LockB = v.lk_b; AddrB = v.addr_b; WDataB = v.wd_b;
   endtask

   task automatic drop_all();
      ReqA = 0; WeA = 0; LockA = 0; AddrA = 0; WDataA = 0;
      ReqB = 0; WeB = 0; LockB = 0; AddrB = 0; WDataB = 0;
   endtask

   // A takes the lock (optionally refreshes it after pre idle cycles), then B
   // must wait exactly 16 idle cycles after A's last access.
   task automatic lock_timeout(input int pre);
      drop_all();
      ReqA = 1; AddrA = 32'h08; LockA = 1;
      @(negedge Clock);
      chk($sformatf("lock%0d_gnt_a", pre), 32'(GntA), 32'd1);
      next_cycle();
      for (int i = 0; i < pre; i++) begin
         ReqA = 0; LockA = 0; ReqB = 1; AddrB = 32'h0C;
         @(negedge Clock);
         chk($sformatf("lock%0d_pre%0d_gnt_b", pre, i), 32'(GntB), 32'd0);
         next_cycle();
      end
      if (pre > 0) begin
         ReqA = 1; LockA = 1; AddrA = 32'h08; ReqB = 1;
         @(negedge Clock);
         chk($sformatf("lock%0d_refresh_gnt_a", pre), 32'(GntA), 32'd1);
         chk($sformatf("lock%0d_refresh_gnt_b", pre), 32'(GntB), 32'd0);
         next_cycle();
      end
      ReqA = 0; LockA = 0; ReqB = 1; AddrB = 32'h0C;
      for (int i = 1; i <= 16; i++) begin
         @(negedge Clock);
         chk($sformatf("lock%0d_idle%0d_gnt_b", pre, i), 32'(GntB), 32'd0);
         next_cycle();
      end
      @(negedge Clock);
      chk($sformatf("lock%0d_release_gnt_b", pre), 32'(GntB), 32'd1);
      chk($sformatf("lock%0d_release_maddr", pre), MemAddress, 32'h0C);
      next_cycle();
      drop_all();
      @(negedge Clock);
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            rst  A: req we lk addr       wdata          B: req we lk addr  wdata     gA gB mwe maddr   rvA rdA          erA rvB rdB      erB chk
      vecs.push_back(mk(0, 1,0,0,32'h08,0,            0,0,0,0,0,              0,0,0,0,       0,0,0,            0,0,0,           1));
      vecs.push_back(mk(1, 1,0,0,32'h04,0,            1,0,0,32'h0C,0,         1,0,0,32'h04,  0,0,0,            0,0,0,           1));
      vecs.push_back(mk(1, 0,0,0,0,0,                 1,0,0,32'h0C,0,         0,1,0,32'h0C,  1,32'h1,0,        0,0,0,           0));
      vecs.push_back(mk(1, 0,0,0,0,0,                 0,0,0,0,0,              0,0,0,0,       0,0,0,            1,32'h3,0,       0));
      vecs.push_back(mk(1, 1,0,0,32'h08,0,            0,0,0,0,0,              1,0,0,32'h08,  0,0,0,            0,0,0,           0));
      vecs.push_back(mk(1, 0,0,0,0,0,                 0,0,0,0,0,              0,0,0,0,       1,32'h2,0,        0,0,0,           0));
      vecs.push_back(mk(1, 1,0,0,32'h14,0,            1,1,1,32'h10,32'h1234,  0,1,1,32'h10,  0,0,0,            0,0,0,           0));
      vecs.push_back(mk(1, 1,0,0,32'h14,0,            1,0,0,32'h10,0,         0,1,0,32'h10,  0,0,0,            1,0,0,           0));
      vecs.push_back(mk(1, 1,0,0,32'h14,0,            0,0,0,0,0,              1,0,0,32'h14,  0,0,0,            1,32'h1234,0,    0));
      vecs.push_back(mk(1, 0,0,0,0,0,                 0,0,0,0,0,              0,0,0,0,       1,32'h5,0,        0,0,0,           0));
      vecs.push_back(mk(1, 1,1,0,32'h80,32'hDEAD,     0,0,0,0,0,              1,0,0,32'h80,  0,0,0,            0,0,0,           0));
      vecs.push_back(mk(1, 1,0,0,32'h00,0,            0,0,0,0,0,              1,0,0,32'h00,  1,0,1,            0,0,0,           0));
      vecs.push_back(mk(1, 0,0,0,0,0,                 0,0,0,0,0,              0,0,0,0,       1,0,0,            0,0,0,           0));
      vecs.push_back(mk(1, 1,1,0,32'h18,32'hA5A50001, 0,0,0,0,0,              1,0,1,32'h18,  0,0,0,            0,0,0,           0));
      vecs.push_back(mk(1, 1,0,0,32'h18,0,            0,0,0,0,0,              1,0,0,32'h18,  1,0,0,            0,0,0,           0));
      vecs.push_back(mk(1, 0,0,0,0,0,                 0,0,0,0,0,              0,0,0,0,       1,32'hA5A50001,0, 0,0,0,           0));
      vecs.push_back(mk(1, 1,0,0,32'h20,0,            1,0,0,32'h24,0,         0,1,0,32'h24,  0,0,0,            0,0,0,           0));
      vecs.push_back(mk(1, 1,0,0,32'h20,0,            1,0,0,32'h28,0,         1,0,0,32'h20,  0,0,0,            1,32'h9,0,       0));
      vecs.push_back(mk(1, 1,0,0,32'h2C,0,            1,0,0,32'h28,0,         0,1,0,32'h28,  1,32'h8,0,        0,0,0,           0));
      vecs.push_back(mk(1, 1,0,0,32'h2C,0,            0,0,0,0,0,              1,0,0,32'h2C,  0,0,0,            1,32'hA,0,       0));
      vecs.push_back(mk(1, 0,0,0,0,0,                 0,0,0,0,0,              0,0,0,0,       1,32'hB,0,        0,0,0,           0));
      vecs.push_back(mk(1, 1,0,1,32'h30,0,            0,0,0,0,0,              1,0,0,32'h30,  0,0,0,            0,0,0,           0));
      vecs.push_back(mk(1, 0,0,0,0,0,                 1,0,0,32'h34,0,         0,0,0,0,       1,32'hC,0,        0,0,0,           0));
      vecs.push_back(mk(0, 1,0,1,32'h38,0,            1,0,0,32'h34,0,         0,0,0,0,       0,0,0,            0,0,0,           0));
      vecs.push_back(mk(1, 0,0,0,0,0,                 1,0,0,32'h34,0,         0,1,0,32'h34,  0,0,0,            0,0,0,           1));
      vecs.push_back(mk(1, 0,0,0,0,0,                 0,0,0,0,0,              0,0,0,0,       0,0,0,            1,32'hD,0,       0));
      vecs.push_back(mk(1, 1,0,0,32'h3C,0,            1,0,0,32'h40,0,         1,0,0,32'h3C,  0,0,0,            0,0,0,           0));
      vecs.push_back(mk(1, 0,0,0,0,0,                 1,0,0,32'h40,0,         0,1,0,32'h40,  1,32'hF,0,        0,0,0,           0));
      vecs.push_back(mk(1, 0,0,0,0,0,                 0,0,0,0,0,              0,0,0,0,       0,0,0,            1,32'h10,0,      0));
      vecs.push_back(mk(1, 0,0,0,0,0,                 1,0,0,32'h104,0,        0,1,0,32'h104, 0,0,0,            0,0,0,           0));
      vecs.push_back(mk(1, 0,0,0,0,0,                 0,0,0,0,0,              0,0,0,0,       0,0,0,            1,0,1,           0));

      mem_load = 1'b1;
      ResetN   = 1'b0;
      drop_all();
      @(posedge Clock);
      #1 mem_load = 1'b0;
      next_cycle();

      foreach (vecs[i]) begin
         apply(vecs[i]);
         @(negedge Clock);
         chk($sformatf("row%0d_gnt_a", i),   32'(GntA),           32'(vecs[i].g_a));
         chk($sformatf("row%0d_gnt_b", i),   32'(GntB),           32'(vecs[i].g_b));
         chk($sformatf("row%0d_mem_we", i),  32'(MemEnableWrite), 32'(vecs[i].mwe));
         chk($sformatf("row%0d_mem_addr", i), MemAddress,         vecs[i].maddr);
         chk($sformatf("row%0d_rvalid_a", i), 32'(RValidA),       32'(vecs[i].rv_a));
         chk($sformatf("row%0d_rvalid_b", i), 32'(RValidB),       32'(vecs[i].rv_b));
         if (vecs[i].rv_a || vecs[i].chk_rd) begin
            chk($sformatf("row%0d_rdata_a", i), RDataA,     vecs[i].rd_a);
            chk($sformatf("row%0d_err_a", i),   32'(ErrA),  32'(vecs[i].er_a));
         end
         if (vecs[i].rv_b || vecs[i].chk_rd) begin
            chk($sformatf("row%0d_rdata_b", i), RDataB,     vecs[i].rd_b);
            chk($sformatf("row%0d_err_b", i),   32'(ErrB),  32'(vecs[i].er_b));
         end
         next_cycle();
      end

      ResetN = 1'b1;
      lock_timeout(0);
      lock_timeout(9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
